// File: rtl/gpregs_pkg.sv
// Shared defaults and constants for the general-purpose register file with
// pending scoreboard.
package gpregs_pkg;

    localparam int GP_DATA_WIDTH = 32;
    localparam int GP_ADDR_WIDTH = 5;

    // Value seen on any read of x0 and loaded into every register on reset.
    localparam logic [GP_DATA_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/gpregs_pending.sv
// Pending scoreboard: one bit per register. Decode sets a bit when it issues a
// producer, writeback clears it, and flush clears every bit. The registered
// count is the popcount of the next-state vector, so it moves on the same edge
// as the bits. x0 is never pending.
module gpregs_pending
    import gpregs_pkg::*;
#(
    parameter int ADDR_WIDTH = GP_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [ADDR_WIDTH-1:0]      issue_reg_i,
    input  logic                       issue_en_i,
    input  logic [ADDR_WIDTH-1:0]      clr_reg_i,
    input  logic                       clr_en_i,
    input  logic                       flush_i,
    output logic [(2**ADDR_WIDTH)-1:0] pending_o,
    output logic [ADDR_WIDTH:0]        count_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int CW       = ADDR_WIDTH + 1;

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [CW-1:0]       count_q, count_d;

    // Next-state pending vector. Flush beats everything, and a same-cycle issue
    // beats a same-cycle writeback to the same register.
    always_comb begin
        pend_d = pend_q;
        if (flush_i) begin
            pend_d = '0;
        end else begin
            if (clr_en_i) begin
                pend_d[clr_reg_i] = 1'b0;
            end
            if (issue_en_i) begin
                pend_d[issue_reg_i] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Popcount of the next-state vector. x0 is skipped because it is never pending.
    always_comb begin
        count_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            count_d = count_d + CW'(pend_d[r]);
        end
    end

    // Pending bits and their count share one register stage.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign pending_o = pend_q;
    assign count_o   = count_q;

endmodule

// File: rtl/gpregs_sb.sv
// General-purpose register file: NUM_READ combinational read ports, one write
// port, optional same-cycle write-to-read bypass, and a per-register pending
// scoreboard used by hazard logic.
//
// Strobe semantics: din_enable, issue_enable and flush are single-cycle
// strobes sampled on the rising edge. There is no handshake and no
// back-pressure; every strobe presented at an edge takes effect at that edge.
module gpregs_sb
    import gpregs_pkg::*;
#(
    parameter int DATA_WIDTH = GP_DATA_WIDTH,
    parameter int ADDR_WIDTH = GP_ADDR_WIDTH,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           nreset,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
    output logic [NUM_READ*DATA_WIDTH-1:0] dout,
    output logic [NUM_READ-1:0]            read_busy,
    input  logic [ADDR_WIDTH-1:0]          write_reg,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic                           din_enable,
    input  logic [ADDR_WIDTH-1:0]          issue_reg,
    input  logic                           issue_enable,
    input  logic                           flush,
    output logic [ADDR_WIDTH:0]            pending_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ZERO_W = DATA_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [DATA_WIDTH-1:0] port_data [NUM_READ];
    logic                  port_busy [NUM_READ];

    gpregs_pending #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pending (
        .clk         (clk),
        .nreset      (nreset),
        .issue_reg_i (issue_reg),
        .issue_en_i  (issue_enable),
        .clr_reg_i   (write_reg),
        .clr_en_i    (din_enable),
        .flush_i     (flush),
        .pending_o   (pending),
        .count_o     (pending_count)
    );

    // Register array write. x0 is never written so it stays at zero.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= ZERO_W;
            end
        end else if (din_enable && (write_reg != '0)) begin
            regs_q[write_reg] <= din;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [ADDR_WIDTH-1:0] idx;
        logic                  hit;

        assign idx = read_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = (BYPASS != 0) && din_enable && (write_reg == idx);

        // Read mux for one port: x0 is hard zero, a bypass hit forwards din and
        // reports not-busy because its producer is completing right now.
        always_comb begin
            port_data[i] = regs_q[idx];
            port_busy[i] = pending[idx];
            if (idx == '0) begin
                port_data[i] = ZERO_W;
                port_busy[i] = 1'b0;
            end else if (hit) begin
                port_data[i] = din;
                port_busy[i] = 1'b0;
            end
        end
    end

    // Pack per-port results onto the flat output buses.
    always_comb begin
        dout      = '0;
        read_busy = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            dout[i*DATA_WIDTH +: DATA_WIDTH] = port_data[i];
            read_busy[i]                     = port_busy[i];
        end
    end

endmodule

// File: tb/tb_gpregs_sb.sv
// Bench for gpregs_sb: two instances (bypass on and off) share stimulus. The
// driver pushes expected read/busy/count views computed from an array-based
// reference model; a negedge monitor pops and compares.
module tb_gpregs_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 2;
  localparam int NREG = 2 ** AW;
  localparam int CW   = AW + 1;
  localparam int SW   = CW + NR + NR * DW;
  localparam int EW   = 2 * SW;

  // clock / reset
  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [NR*AW-1:0] read_reg;
  logic [AW-1:0]    write_reg;
  logic [AW-1:0]    issue_reg;
  logic [DW-1:0]    din;
  logic             din_enable;
  logic             issue_enable;
  logic             flush;

  logic [NR*DW-1:0] dout_b, dout_n;
  logic [NR-1:0]    busy_b, busy_n;
  logic [CW-1:0]    cnt_b, cnt_n;

  gpregs_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(1)) u_dut (
    .clk(clk), .nreset(nreset), .read_reg(read_reg), .dout(dout_b), .read_busy(busy_b),
    .write_reg(write_reg), .din(din), .din_enable(din_enable), .issue_reg(issue_reg),
    .issue_enable(issue_enable), .flush(flush), .pending_count(cnt_b)
  );

  gpregs_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .BYPASS(0)) u_dut_nb (
    .clk(clk), .nreset(nreset), .read_reg(read_reg), .dout(dout_n), .read_busy(busy_n),
    .write_reg(write_reg), .din(din), .din_enable(din_enable), .issue_reg(issue_reg),
    .issue_enable(issue_enable), .flush(flush), .pending_count(cnt_n)
  );

  // reference model: register contents and the set of registers awaiting a producer
  logic [DW-1:0] reg_m [NREG];
  bit            pend_m [NREG];

  // scoreboard
  logic [EW-1:0] exp_q [$];
  string         name_q [$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [SW-1:0] expect_view(input bit bypass);
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    b;
    logic [AW-1:0]    r;
    int               cnt;
    cnt = 0;
    for (int k = 0; k < NREG; k++) cnt += int'(pend_m[k]);
    d = '0;
    b = '0;
    for (int i = 0; i < NR; i++) begin
      r = read_reg[i*AW +: AW];
      if (r == 0) begin
        d[i*DW +: DW] = '0;
        b[i] = 1'b0;
      end else if (bypass && din_enable && write_reg == r) begin
        d[i*DW +: DW] = din;
        b[i] = 1'b0;
      end else begin
        d[i*DW +: DW] = reg_m[r];
        b[i] = pend_m[r];
      end
    end
    return {CW'(cnt), b, d};
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NREG; k++) begin
      reg_m[k]  = '0;
      pend_m[k] = 1'b0;
    end
  endfunction

  // driver: one clock of stimulus, expectation pushed before the monitor samples
  task automatic step(input logic [AW-1:0] rd0, input logic [AW-1:0] rd1,
                      input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                      input logic ie, input logic [AW-1:0] ir, input logic fl,
                      input string nm);
    read_reg     = {rd1, rd0};
    din_enable   = we;
    write_reg    = wr;
    din          = wd;
    issue_enable = ie;
    issue_reg    = ir;
    flush        = fl;
    exp_q.push_back({expect_view(1'b1), expect_view(1'b0)});
    name_q.push_back(nm);
    @(posedge clk);
    if (we && wr != 0) reg_m[wr] = wd;
    if (fl) begin
      for (int k = 0; k < NREG; k++) pend_m[k] = 1'b0;
    end else begin
      if (we) pend_m[wr] = 1'b0;
      if (ie && ir != 0) pend_m[ir] = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset(input string nm);
    nreset       = 1'b0;
    din_enable   = 1'b0;
    issue_enable = 1'b0;
    flush        = 1'b0;
    write_reg    = '0;
    issue_reg    = '0;
    din          = '0;
    read_reg     = {AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1))};
    model_clear();
    exp_q.push_back({expect_view(1'b1), expect_view(1'b0)});
    name_q.push_back(nm);
    @(negedge clk);
    #1 nreset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic void check(input string nm, input string field,
                                input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, field, act, exp);
    end
  endfunction

  // monitor: compares both instances whenever an expectation is outstanding
  logic [EW-1:0] e;
  string         e_nm;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      e_nm = name_q.pop_front();
      check(e_nm, "dout_byp",  dout_b, e[SW +: NR*DW]);
      check(e_nm, "busy_byp",  (NR*DW)'(busy_b), (NR*DW)'(e[SW + NR*DW +: NR]));
      check(e_nm, "count_byp", (NR*DW)'(cnt_b),  (NR*DW)'(e[SW + NR*DW + NR +: CW]));
      check(e_nm, "dout_nb",   dout_n, e[0 +: NR*DW]);
      check(e_nm, "busy_nb",   (NR*DW)'(busy_n), (NR*DW)'(e[NR*DW +: NR]));
      check(e_nm, "count_nb",  (NR*DW)'(cnt_n),  (NR*DW)'(e[NR*DW + NR +: CW]));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset("reset");
    step(0, 0, 0, 0, 0, 0, 0, 0, "rst_x0");

    // x0 is hard-wired
    step(0, 0, 1, 0, 32'hFF, 0, 0, 0, "x0_wr");
    step(0, 0, 0, 0, 0, 0, 0, 0, "x0_rd");
    step(0, 0, 0, 0, 0, 1, 0, 0, "x0_issue");
    step(0, 0, 0, 0, 0, 0, 0, 0, "x0_cnt");

    // plain write then read on both ports
    step(0, 0, 1, 1, 32'h12, 0, 0, 0, "x1_wr");
    step(1, 1, 0, 0, 0, 0, 0, 0, "x1_rd");

    // bypass vs registered visibility
    step(0, 0, 1, 2, 32'h5, 0, 0, 0, "x2_wr5");
    step(2, 2, 1, 2, 32'hAB, 0, 0, 0, "x2_bypass");
    step(2, 2, 0, 0, 0, 0, 0, 0, "x2_next");

    // scoreboard set/clear and issue-wins priority
    step(3, 4, 0, 0, 0, 1, 3, 0, "iss3");
    step(3, 4, 0, 0, 0, 1, 4, 0, "iss4");
    step(3, 4, 0, 0, 0, 0, 0, 0, "busy34");
    step(3, 4, 1, 3, 32'h33, 1, 3, 0, "wb3_iss3");
    step(3, 4, 0, 0, 0, 0, 0, 0, "still3");
    step(3, 4, 1, 4, 32'h44, 0, 0, 0, "wb4");
    step(3, 4, 0, 0, 0, 0, 0, 0, "cnt1");
    step(9, 9, 1, 9, 32'h99, 0, 0, 0, "wb_nonpend");
    step(9, 3, 0, 0, 0, 1, 3, 0, "reissue3");

    // flush beats same-cycle issue
    step(5, 6, 0, 0, 0, 1, 5, 0, "iss5");
    step(5, 6, 0, 0, 0, 1, 6, 0, "iss6");
    step(7, 8, 0, 0, 0, 1, 7, 0, "iss7");
    step(7, 8, 0, 0, 0, 1, 8, 1, "flush_iss8");
    step(5, 8, 0, 0, 0, 0, 0, 0, "after_flush");

    // reset in the middle of activity
    step(10, 11, 1, 10, 32'hDEAD, 1, 11, 0, "pre_rst_a");
    step(10, 11, 1, 12, 32'hBEEF, 1, 12, 0, "pre_rst_b");
    do_reset("mid_reset");
    step(10, 11, 0, 0, 0, 0, 0, 0, "post_rst_rd");
    step(0, 0, 1, 13, 32'h1313, 0, 0, 0, "post_rst_wr");
    step(13, 12, 0, 0, 0, 0, 0, 0, "post_rst_chk");

    // randomized traffic, indices concentrated on low registers to force collisions
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] r0, r1, w, ir;
      r0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG-1)) : AW'($urandom_range(0, 7));
      r1 = AW'($urandom_range(0, 7));
      w  = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(0, NREG-1)) : AW'($urandom_range(0, 7));
      ir = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ir = w;
      if ($urandom_range(0, 3) == 0) r0 = w;
      step(r0, r1, 1'($urandom_range(0, 1)), w, $urandom,
           1'($urandom_range(0, 1)), ir, ($urandom_range(0, 24) == 0), "rand");
      if (n == 300) do_reset("rand_reset");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
